press_event_classifier: RTL and testbench

Consumes the debounced level of one discrete input (push-button, ignition or similar) and turns it into single-entry events for the MCU register interface. Events are short press, long press reached, and long press released, each with a press duration measured in ticks of an external time-base strobe. It sits directly downstream of the per-pin debouncer and upstream of the register/interrupt bank. A one-deep event buffer with valid/ack handshake and a sticky overrun flag decouples it from the MCU.

---
 rtl/press_event_classifier.sv | 153 +++++++++++++++
 tb/tb_press_event_classifier.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/press_event_classifier.sv
// Classifies a debounced input into SHORT / LONG / LONG_REL events with tick-based
// press durations, held in a one-deep valid/ack buffer with a sticky overrun flag.
module press_event_classifier #(
    parameter int   CNT_WIDTH    = 16,
    parameter int   LONG_TICKS   = 1000,
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_in,
    input  logic                 i_evt_ack,
    input  logic                 i_ovr_clr,
    output logic                 o_evt_valid,
    output logic [1:0]           o_evt_code,
    output logic [CNT_WIDTH-1:0] o_evt_dur,
    output logic                 o_pressed,
    output logic                 o_evt_ovr
);

    localparam logic [CNT_WIDTH-1:0] LONG_VAL      = CNT_WIDTH'(LONG_TICKS);
    localparam logic [1:0]           CODE_SHORT    = 2'b01;
    localparam logic [1:0]           CODE_LONG     = 2'b10;
    localparam logic [1:0]           CODE_LONG_REL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_primed;
    logic                 r_act;
    logic                 r_act_q;
    logic                 r_tick;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_act;
    logic                 w_press;
    logic                 w_release;
    logic                 w_emit;
    logic [1:0]           w_emit_code;
    logic [CNT_WIDTH-1:0] w_emit_dur;
    logic                 w_load;
    logic                 w_drop;

    assign w_act = (i_in == ACTIVE_LEVEL);

    // The priming clock loads both level stages with the current input so a
    // level already active at reset release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_primed <= 1'b0;
            r_act    <= 1'b0;
            r_act_q  <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            r_act    <= w_act;
            r_act_q  <= r_primed ? r_act : w_act;
            r_tick   <= i_tick;
        end
    end

    assign w_press   = r_primed &  r_act & ~r_act_q;
    assign w_release = r_primed & ~r_act &  r_act_q;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A release takes priority over a coincident tick, so the tick is not counted.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_emit       = 1'b0;
        w_emit_code  = CODE_SHORT;
        w_emit_dur   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                end
            end
            ST_PRESSED: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                    w_emit       = 1'b1;
                    w_emit_code  = CODE_SHORT;
                end else if (r_tick) begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == LONG_VAL) begin
                        w_state_next = ST_LONG;
                        w_emit       = 1'b1;
                        w_emit_code  = CODE_LONG;
                        w_emit_dur   = LONG_VAL;
                    end
                end
            end
            ST_LONG: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                    w_emit       = 1'b1;
                    w_emit_code  = CODE_LONG_REL;
                end else if (r_tick) begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_load = w_emit & (~o_evt_valid | i_evt_ack);
    assign w_drop = w_emit &  o_evt_valid & ~i_evt_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_evt_valid <= 1'b0;
            o_evt_code  <= 2'b00;
            o_evt_dur   <= '0;
            o_evt_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                o_evt_valid <= 1'b1;
                o_evt_code  <= w_emit_code;
                o_evt_dur   <= w_emit_dur;
            end else if (i_evt_ack) begin
                o_evt_valid <= 1'b0;
            end
            if (w_drop) begin
                o_evt_ovr <= 1'b1;
            end else if (i_ovr_clr) begin
                o_evt_ovr <= 1'b0;
            end
        end
    end

    assign o_pressed = (r_state != ST_IDLE);

endmodule

// File: tb/tb_press_event_classifier.sv
// Bench for press_event_classifier: a 16-bit and a 4-bit counter instance share stimulus
// and are compared to a tick-counting event model, a directed table and hand sequences.
module tb_press_event_classifier;

    localparam int LT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        in_l = 1'b0;
    logic        ack = 1'b0;
    logic        clr = 1'b0;

    logic        a_valid, a_pressed, a_ovr;
    logic [1:0]  a_code;
    logic [15:0] a_dur;
    logic        b_valid, b_pressed, b_ovr;
    logic [1:0]  b_code;
    logic [3:0]  b_dur;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    press_event_classifier #(.CNT_WIDTH(16), .LONG_TICKS(LT), .ACTIVE_LEVEL(1'b1)) dut16 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_in(in_l), .i_evt_ack(ack), .i_ovr_clr(clr),
        .o_evt_valid(a_valid), .o_evt_code(a_code), .o_evt_dur(a_dur),
        .o_pressed(a_pressed), .o_evt_ovr(a_ovr)
    );

    press_event_classifier #(.CNT_WIDTH(4), .LONG_TICKS(LT), .ACTIVE_LEVEL(1'b1)) dut4 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_in(in_l), .i_evt_ack(ack), .i_ovr_clr(clr),
        .o_evt_valid(b_valid), .o_evt_code(b_code), .o_evt_dur(b_dur),
        .o_pressed(b_pressed), .o_evt_ovr(b_ovr)
    );

    // Reference: input history as a short delay line, press length as an unbounded tick count.
    int         m_edges;
    bit         m_d1, m_d2, m_t1;
    bit         m_active, m_long;
    int         m_ticks;
    bit         m_v, m_ovr;
    logic [1:0] m_code;
    int         m_dur;

    task automatic model_reset();
        m_edges = 0; m_d1 = 0; m_d2 = 0; m_t1 = 0;
        m_active = 0; m_long = 0; m_ticks = 0;
        m_v = 0; m_ovr = 0; m_code = 2'b00; m_dur = 0;
    endtask

    task automatic model_edge();
        bit a_now;
        bit drop;
        int ev_code;
        int ev_dur;
        a_now   = (in_l == 1'b1);
        ev_code = 0;
        ev_dur  = 0;
        drop    = 0;
        if (m_edges > 0) begin
            if (!m_active) begin
                if (m_d1 && !m_d2) begin
                    m_active = 1; m_long = 0; m_ticks = 0;
                end
            end else if (!m_d1 && m_d2) begin
                ev_code  = m_long ? 3 : 1;
                ev_dur   = m_ticks;
                m_active = 0;
            end else if (m_t1) begin
                m_ticks++;
                if (m_ticks == LT) begin
                    m_long = 1; ev_code = 2; ev_dur = LT;
                end
            end
        end
        if (ev_code != 0) begin
            if (!m_v || ack) begin
                m_v = 1; m_code = ev_code[1:0]; m_dur = ev_dur;
            end else begin
                drop = 1;
            end
        end else if (ack) begin
            m_v = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
        m_d2 = (m_edges == 0) ? a_now : m_d1;
        m_d1 = a_now;
        m_t1 = tick;
        m_edges++;
    endtask

    function automatic int clamp(int d, int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [31:0] pack(logic v, logic [1:0] c, logic [15:0] d, logic p, logic o);
        return {11'd0, v, c, d, p, o};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("dut16_vs_model", pack(a_valid, a_code, a_dur, a_pressed, a_ovr),
              pack(m_v, m_code, 16'(clamp(m_dur, 65535)), m_active, m_ovr));
        check("dut4_vs_model", pack(b_valid, b_code, {12'd0, b_dur}, b_pressed, b_ovr),
              pack(m_v, m_code, 16'(clamp(m_dur, 15)), m_active, m_ovr));
    endtask

    task automatic step(bit t, bit i, bit a, bit c);
        tick = t; in_l = i; ack = a; clr = c;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_edge();
        cmp_model();
    endtask

    typedef struct {
        bit         t, i, a, c;
        bit         v;
        logic [1:0] code;
        int         dur;
        bit         p, o;
    } vec_t;

    vec_t tbl[26];

    initial begin
        // Columns: tick in ack clr | valid code dur pressed ovr (after the edge)
        tbl[0]  = '{0,0,0,0, 0,2'd0,0,0,0};
        tbl[1]  = '{0,1,0,0, 0,2'd0,0,0,0};
        tbl[2]  = '{0,1,0,0, 0,2'd0,0,1,0};
        tbl[3]  = '{1,1,0,0, 0,2'd0,0,1,0};
        tbl[4]  = '{1,1,0,0, 0,2'd0,0,1,0};
        tbl[5]  = '{1,1,0,0, 0,2'd0,0,1,0};
        tbl[6]  = '{0,0,0,0, 0,2'd0,0,1,0};
        tbl[7]  = '{0,0,0,0, 1,2'd1,3,0,0};
        tbl[8]  = '{0,0,1,0, 0,2'd1,3,0,0};
        tbl[9]  = '{0,0,0,0, 0,2'd1,3,0,0};
        tbl[10] = '{0,1,0,0, 0,2'd1,3,0,0};
        tbl[11] = '{1,1,0,0, 0,2'd1,3,1,0};
        tbl[12] = '{1,1,0,0, 0,2'd1,3,1,0};
        tbl[13] = '{1,1,0,0, 0,2'd1,3,1,0};
        tbl[14] = '{1,1,0,0, 0,2'd1,3,1,0};
        tbl[15] = '{1,0,0,0, 0,2'd1,3,1,0};
        tbl[16] = '{0,0,0,0, 1,2'd1,4,0,0};
        tbl[17] = '{0,1,0,0, 1,2'd1,4,0,0};
        tbl[18] = '{0,0,0,0, 1,2'd1,4,1,0};
        tbl[19] = '{0,0,0,0, 1,2'd1,4,0,1};
        tbl[20] = '{0,0,0,1, 1,2'd1,4,0,0};
        tbl[21] = '{0,1,0,0, 1,2'd1,4,0,0};
        tbl[22] = '{0,0,0,0, 1,2'd1,4,1,0};
        tbl[23] = '{0,0,1,0, 1,2'd1,0,0,0};
        tbl[24] = '{0,0,1,0, 0,2'd1,0,0,0};
        tbl[25] = '{0,0,1,0, 0,2'd1,0,0,0};

        model_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("reset_state", pack(a_valid, a_code, a_dur, a_pressed, a_ovr), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 26; k++) begin
            step(tbl[k].t, tbl[k].i, tbl[k].a, tbl[k].c);
            check($sformatf("table_row%0d", k),
                  pack(a_valid, a_code, a_dur, a_pressed, a_ovr),
                  pack(tbl[k].v, tbl[k].code, 16'(tbl[k].dur), tbl[k].p, tbl[k].o));
        end

        // Input already active across reset release: no event at all.
        rst = 1'b1;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step(1, 1, 0, 0);
            step(0, 1, 0, 0);
            check("prime_pressed", {31'd0, a_pressed}, 32'd0);
        end
        for (int n = 0; n < 3; n++) step(0, 0, 0, 0);
        check("prime_no_event", pack(a_valid, a_code, a_dur, a_pressed, a_ovr), 32'd0);

        // 15-tick hold: LONG one cycle after the 10th tick, then LONG_REL.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int n = 1; n <= 15; n++) begin
            step(1, 1, 0, 0);
            step(0, 1, 0, 0);
            if (n == 10) begin
                check("long_evt16", pack(a_valid, a_code, a_dur, 1'b0, 1'b0), pack(1'b1, 2'd2, 16'd10, 1'b0, 1'b0));
                check("long_evt4", {26'd0, b_valid, b_code, b_dur}, {26'd0, 1'b1, 2'd2, 4'd10});
                step(0, 1, 1, 0);
                check("long_acked", {31'd0, a_valid}, 32'd0);
            end
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("longrel_evt16", pack(a_valid, a_code, a_dur, a_pressed, a_ovr), pack(1'b1, 2'd3, 16'd15, 1'b0, 1'b0));
        check("longrel_evt4", {26'd0, b_valid, b_code, b_dur}, {26'd0, 1'b1, 2'd3, 4'd15});

        // 30-tick hold: 4-bit duration saturates at 15; ack pulses on every gap cycle.
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int n = 1; n <= 30; n++) begin
            step(1, 1, 0, 0);
            step(0, 1, 1, 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("sat_longrel16", {14'd0, a_valid, a_code, a_dur}, {14'd0, 1'b1, 2'd3, 16'd30});
        check("sat_longrel4", {26'd0, b_valid, b_code, b_dur}, {26'd0, 1'b1, 2'd3, 4'd15});

        // Asynchronous reset in the middle of a hold.
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int n = 0; n < 5; n++) begin
            step(1, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst16", pack(a_valid, a_code, a_dur, a_pressed, a_ovr), 32'd0);
        check("async_rst4", pack(b_valid, b_code, {12'd0, b_dur}, b_pressed, b_ovr), 32'd0);
        model_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step(1, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        for (int n = 0; n < 3; n++) step(0, 0, 0, 0);
        check("post_rst_no_event", pack(a_valid, a_code, a_dur, a_pressed, a_ovr), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit nt, ni, na, nc;
            ni = ($urandom_range(0, 29) == 0) ? ~in_l : in_l;
            nt = ($urandom_range(0, 2) == 0);
            na = ($urandom_range(0, 7) == 0);
            nc = ($urandom_range(0, 15) == 0);
            step(nt, ni, na, nc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
